real_mac_accum: RTL and testbench
=================================

Name: real_mac_accum

Overview:
Streaming fixed-point multiply-accumulate stage placed directly downstream of the svreal arithmetic operators. It consumes pairs of fixed-point operands, with independent width and exponent per port, over a valid/ready handshake. It multiplies each pair, aligns the product to the output exponent, and accumulates with saturation. At the end of each frame it emits one accumulated fixed-point result and a sticky overflow flag.

Parameters:
A_WIDTH, 16, width of operand a (signed two's complement)
A_EXP, -8, exponent of a (value = a_i * 2^A_EXP)
B_WIDTH, 17, width of operand b
B_EXP, -9, exponent of b
O_WIDTH, 24, width of accumulator/result
O_EXP, -12, exponent of accumulator/result

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
a_i  in  A_WIDTH  operand a, signed
b_i  in  B_WIDTH  operand b, signed
in_last  in  1  marks the final beat of a frame
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat
out_data  out  O_WIDTH  accumulated frame result, signed, exponent O_EXP
out_ovf  out  1  at least one saturation occurred in this frame
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result

Behaviour:
- Single clock `clk`. All state resets synchronously when `rst`=1 on a rising edge.
- Reset values:
  - Pipeline valid bits, accumulator, and overflow sticky all 0.
  - out_valid=0, out_data=0, out_ovf=0.
  - in_ready=1 in the first cycle after reset.
- stall = out_valid & ~out_ready. in_ready = ~stall (combinational). When stall=1, no pipeline register changes.
- Stage 1, on an accepted beat (in_valid & in_ready):
  - Register the full-precision signed product p = a_i*b_i, width A_WIDTH+B_WIDTH, exponent PE = A_EXP+B_EXP.
  - Register v1=1 and last1=in_last. If no beat is accepted and stall=0, v1 <= 0.
- Stage 2, when v1=1 and stall=0, align p to O_EXP:
  - PE < O_EXP: arithmetic right shift by O_EXP-PE (floor toward -inf).
  - PE > O_EXP: sign-extended left shift by PE-O_EXP.
  - PE = O_EXP: no shift.
  - Alignment is done at width max(A_WIDTH+B_WIDTH, O_WIDTH)+|PE-O_EXP|+2 so no bits are lost before saturation.
- Sum s = acc + aligned, at the wide width. Saturate s to [-2^(O_WIDTH-1), 2^(O_WIDTH-1)-1]. If clipped, the overflow sticky is set.
- If last1=0: acc <= sat(s).
- If last1=1:
  - out_data <= sat(s); out_ovf <= sticky | clip_now; out_valid <= 1.
  - acc <= 0 and sticky <= 0, so the next frame starts clean in the same edge.
- Latency: a last beat accepted in cycle N gives out_valid=1 in cycle N+2. Throughput is 1 beat/cycle when out_ready=1.
- out_valid clears on the edge where out_valid & out_ready, unless a new last result is produced in the same edge; then the new result loads and out_valid stays 1.
- Results are held stable while out_valid=1 and out_ready=0.
- Single-beat frame (in_last on the first beat): result = sat(aligned p).
- in_valid=0 gaps mid-frame are allowed; the accumulator holds.
- rst mid-frame discards the partial accumulation and any pending result.
- Input data is ignored when in_valid=0. No X propagation from ignored inputs into state.

Test Plan:
- Defaults, PE=-17 (right shift 5). Frame (1.5,2.0), (-0.5,1.0), (0.25,4.0 last); raw a=384,-128,64, b=1024,512,2048 -> one result, out_data=14336 (3.5), out_ovf=0, out_valid 2 cycles after the last accept.
- Rounding: single beat a=1 (2^-8), b=1 (2^-9) -> out_data=0. Then a=-1, b=1 -> out_data=-1 (floor).
- Saturation: a=100.0 (25600), b=100.0 (51200), last -> out_data=8388607, out_ovf=1. Next frame (1.0,1.0 last) -> out_data=4096, out_ovf=0.
- Backpressure: hold out_ready=0 with a result pending -> in_ready=0, out_data stable, offered beats not consumed. Raise out_ready -> in_ready=1 the same cycle, and the next frame's result is correct.
- Back-to-back single-beat frames at full rate with out_ready=1 -> one result per cycle, in order, no drops.
- Reset mid-frame after two beats, then a single beat (1.0,1.0 last) -> out_data=4096 with no residue; all outputs 0 during reset.

Source files
------------

// File: rtl/real_mac_accum.sv
// Streaming fixed-point multiply-accumulate with per-frame saturating accumulation.
// Two pipeline stages: operand product, then alignment/accumulate/result register.
module real_mac_accum #(
  parameter int A_WIDTH = 16,
  parameter int A_EXP   = -8,
  parameter int B_WIDTH = 17,
  parameter int B_EXP   = -9,
  parameter int O_WIDTH = 24,
  parameter int O_EXP   = -12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] a_i,
  input  logic [B_WIDTH-1:0] b_i,
  input  logic               in_last,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [O_WIDTH-1:0] out_data,
  output logic               out_ovf,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int PW     = A_WIDTH + B_WIDTH;
  localparam int PE     = A_EXP + B_EXP;
  localparam int SHIFT  = O_EXP - PE;  // positive means shift right
  localparam int ABS_SH = (SHIFT < 0) ? -SHIFT : SHIFT;
  localparam int W      = ((PW > O_WIDTH) ? PW : O_WIDTH) + ABS_SH + 2;

  localparam logic signed [W-1:0] SAT_MAX = {{(W-O_WIDTH+1){1'b0}}, {(O_WIDTH-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {{(W-O_WIDTH+1){1'b1}}, {(O_WIDTH-1){1'b0}}};

  logic                      stall;
  logic                      accept;
  logic signed [PW-1:0]      prod;
  logic signed [PW-1:0]      p_r;
  logic                      v1;
  logic                      last1;
  logic signed [O_WIDTH-1:0] acc;
  logic                      sticky;

  logic signed [W-1:0]       p_ext;
  logic signed [W-1:0]       aligned;
  logic signed [W-1:0]       acc_ext;
  logic signed [W-1:0]       sum;
  logic                      clip_hi;
  logic                      clip_lo;
  logic                      clip_now;
  logic signed [O_WIDTH-1:0] sat_val;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  assign prod = $signed(a_i) * $signed(b_i);

  // Work at W bits so the shift and the add can never lose bits before clipping.
  assign p_ext   = {{(W-PW){p_r[PW-1]}}, p_r};
  assign acc_ext = {{(W-O_WIDTH){acc[O_WIDTH-1]}}, acc};

  generate
    if (SHIFT > 0) begin : g_shr
      assign aligned = p_ext >>> SHIFT;
    end else if (SHIFT < 0) begin : g_shl
      assign aligned = p_ext <<< ABS_SH;
    end else begin : g_noshift
      assign aligned = p_ext;
    end
  endgenerate

  assign sum      = acc_ext + aligned;
  assign clip_hi  = (sum > SAT_MAX);
  assign clip_lo  = (sum < SAT_MIN);
  assign clip_now = clip_hi | clip_lo;

  always_comb begin
    sat_val = sum[O_WIDTH-1:0];
    if (clip_hi) sat_val = SAT_MAX[O_WIDTH-1:0];
    else if (clip_lo) sat_val = SAT_MIN[O_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_r       <= '0;
      v1        <= 1'b0;
      last1     <= 1'b0;
      acc       <= '0;
      sticky    <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      v1 <= accept;
      if (accept) begin
        p_r   <= prod;
        last1 <= in_last;
      end
      // With no stall any held result is being taken now, so out_valid follows stage 2.
      out_valid <= v1 & last1;
      if (v1) begin
        if (last1) begin
          out_data <= sat_val;
          out_ovf  <= sticky | clip_now;
          acc      <= '0;
          sticky   <= 1'b0;
        end else begin
          acc    <= sat_val;
          sticky <= sticky | clip_now;
        end
      end
    end
  end

endmodule

// File: tb/tb_real_mac_accum.sv
// Directed bench for real_mac_accum: expected results are queued at stimulus time
// and a separate monitor compares them against each accepted output.
module tb_real_mac_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_i;
  logic [16:0] b_i;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] out_data;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int n_push = 0;
  longint exp_q[$];

  real_mac_accum dut (
    .clk(clk), .rst(rst), .a_i(a_i), .b_i(b_i), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Expected entries pack data and overflow as data*2 + ovf.
  task automatic push_exp(input longint data, input bit ovf);
    exp_q.push_back(data * 2 + longint'(ovf));
    n_push++;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      longint e;
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", longint'($signed(out_data)), 0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", longint'($signed(out_data)), e >>> 1);
        check("out_ovf", longint'(out_ovf), e & 1);
      end
    end
  end

  // Called just after a posedge; returns just after the edge that accepted the beat.
  task automatic beat(input int a, input int b, input bit last);
    int n;
    a_i = 16'(a);
    b_i = 17'(b);
    in_last = last;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("beat_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drop();
    in_valid = 1'b0;
    in_last = 1'b0;
    a_i = 16'hxxxx;
    b_i = 17'h0_xxxx;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) check(name, 0, 1);
  endtask

  int streak;
  int max_streak;
  bit track;
  always @(negedge clk) begin
    if (track) begin
      streak = out_valid ? streak + 1 : 0;
      if (streak > max_streak) max_streak = streak;
    end
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    track = 1'b0;
    streak = 0;
    max_streak = 0;
    drop();
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_data", longint'(out_data), 0);
    check("reset_out_ovf", longint'(out_ovf), 0);
    check("reset_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;

    // Three-beat frame: 3.0 - 0.5 + 1.0 = 3.5 -> 14336; check the two-cycle latency.
    push_exp(14336, 0);
    beat(384, 1024, 0);
    beat(-128, 512, 0);
    beat(64, 2048, 1);
    drop();
    check("latency_n1_valid", longint'(out_valid), 0);
    @(posedge clk);
    #1;
    check("latency_n2_valid", longint'(out_valid), 1);
    idle(3);

    // Floor toward minus infinity on the right shift.
    push_exp(0, 0);
    beat(1, 1, 1);
    push_exp(-1, 0);
    beat(-1, 1, 1);
    drop();
    idle(4);

    // Saturation, then a clean frame afterwards.
    push_exp(8388607, 1);
    beat(25600, 51200, 1);
    push_exp(4096, 0);
    beat(256, 512, 1);
    drop();
    idle(4);

    // Backpressure: result held, in_ready low, offered beat not taken.
    out_ready = 1'b0;
    push_exp(4096, 0);
    beat(256, 512, 1);
    drop();
    wait_out_valid("bp_wait_valid_timeout");
    push_exp(8192, 0);
    a_i = 16'd512;
    b_i = 17'd512;
    in_last = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", longint'(in_ready), 0);
      check("bp_out_data_hold", longint'($signed(out_data)), 4096);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    drop();
    idle(5);

    // Back-to-back single-beat frames: one result per cycle in order.
    track = 1'b1;
    push_exp(4096, 0);
    beat(256, 512, 1);
    push_exp(8192, 0);
    beat(512, 512, 1);
    push_exp(-4096, 0);
    beat(-256, 512, 1);
    push_exp(0, 0);
    beat(0, 12345, 1);
    push_exp(12288, 0);
    beat(768, 512, 1);
    drop();
    idle(5);
    track = 1'b0;
    check("b2b_output_run", longint'(max_streak), 5);

    // Reset mid-frame discards the partial sum.
    beat(256, 512, 0);
    beat(256, 512, 0);
    drop();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_ovf", longint'(out_ovf), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", longint'(in_ready), 1);
    push_exp(4096, 0);
    beat(256, 512, 1);
    drop();
    idle(6);

    check("outputs_seen", longint'(n_out), longint'(n_push));
    check("queue_empty", longint'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
